// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one-outstanding imem requests and buffers returned words for decode.
// Optional macro IF_PERF_CNT_EN adds saturating bubble and redirect counters.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INST   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ID,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] NPC_IF,
  output logic [15:0] INST_IF,
  output logic        VALID_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] perf_bubble_cnt,
  output logic [15:0] perf_redirect_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // S_IDLE: buffer full, no request | S_FETCH: live request | S_DROP: draining a cancelled request
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic [15:0]     addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]     fifo_npc_q  [FIFO_DEPTH];
  logic [15:0]     fifo_inst_q [FIFO_DEPTH];

  logic valid;
  logic pop;
  logic push;

  always_comb begin
    valid      = (cnt_q != '0);
    pop        = valid && !stall_ID;
    push       = (state_q == S_FETCH) && imem_ack && !redirect;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect) begin
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      if (push) fetch_pc_d = fetch_pc_q + 16'd1;
    end

    // A redirect forces cnt_d to zero, so it always re-enters S_FETCH from the ack paths.
    case (state_q)
      S_IDLE: begin
        if (cnt_d < CW'(FIFO_DEPTH)) begin
          state_d = S_FETCH;
          addr_d  = fetch_pc_d;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (cnt_d < CW'(FIFO_DEPTH)) addr_d = fetch_pc_d;
          else state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_FETCH;
          addr_d  = fetch_pc_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_npc_q[wr_ptr_q]  <= fetch_pc_q + 16'd1;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr = addr_q;
  assign VALID_IF  = valid;
  assign NPC_IF    = valid ? fifo_npc_q[rd_ptr_q]  : 16'h0000;
  assign INST_IF   = valid ? fifo_inst_q[rd_ptr_q] : NOP_INST;

`ifdef IF_PERF_CNT_EN
  logic [15:0] bubble_q, bubble_d;
  logic [15:0] redir_q, redir_d;

  always_comb begin
    bubble_d = bubble_q;
    redir_d  = redir_q;
    if (!valid && !stall_ID && (bubble_q != 16'hFFFF)) bubble_d = bubble_q + 16'd1;
    if (redirect && (redir_q != 16'hFFFF))             redir_d  = redir_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      redir_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      redir_q  <= redir_d;
    end
  end

  assign perf_bubble_cnt   = bubble_q;
  assign perf_redirect_cnt = redir_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model returns 16'hA000+addr after a programmable wait.
// Covers streaming, stall back-pressure, redirects, PC wrap and reset during a drained request.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ID;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] NPC_IF;
  logic [15:0] INST_IF;
  logic        VALID_IF;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_bubble_cnt;
  logic [15:0] perf_redirect_cnt;
`endif

  int   lat;
  int   wcnt;
  logic force_ack;
  int   n_chk;
  int   n_pass;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_ID    (stall_ID),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .NPC_IF      (NPC_IF),
    .INST_IF     (INST_IF),
    .VALID_IF    (VALID_IF)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_bubble_cnt   (perf_bubble_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  // memory: ack once the request has been waiting lat cycles; force_ack injects a stray strobe
  assign imem_ack   = (imem_req && (wcnt >= lat)) || force_ack;
  assign imem_rdata = 16'hA000 + imem_addr;

  always @(posedge clk) begin
    if (imem_req && imem_ack) wcnt <= 0;
    else if (imem_req)        wcnt <= wcnt + 1;
    else                      wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req",   {15'd0, imem_req}, 16'h0000);
    chk("rst_valid", {15'd0, VALID_IF}, 16'h0000);
    chk("rst_inst",  INST_IF,           16'h0000);
    chk("rst_npc",   NPC_IF,            16'h0000);
    chk("rst_addr",  imem_addr,         16'h0000);
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; stall_ID = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    force_ack = 1'b0; lat = 0; wcnt = 0;

    // streaming with zero-wait memory
    do_reset();
    tick();
    chk("s_req1",   {15'd0, imem_req}, 16'h0001);
    chk("s_valid0", {15'd0, VALID_IF}, 16'h0000);
    chk("s_addr0",  imem_addr,         16'h0000);
    tick();
    chk("s_inst0", INST_IF, 16'hA000);
    chk("s_npc0",  NPC_IF,  16'h0001);
    tick();
    chk("s_inst1", INST_IF, 16'hA001);
    chk("s_npc1",  NPC_IF,  16'h0002);
    tick();
    chk("s_inst2", INST_IF, 16'hA002);
    chk("s_npc2",  NPC_IF,  16'h0003);

    // decode stall for 5 cycles: buffer fills, request drops, head frozen
    stall_ID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_req",   {15'd0, imem_req}, 16'h0000);
      chk("st_valid", {15'd0, VALID_IF}, 16'h0001);
      chk("st_inst",  INST_IF,           16'hA002);
      chk("st_npc",   NPC_IF,            16'h0003);
    end
    stall_ID = 1'b0;
    tick();
    chk("st_rel_inst", INST_IF,           16'hA003);
    chk("st_rel_npc",  NPC_IF,            16'h0004);
    chk("st_rel_req",  {15'd0, imem_req}, 16'h0001);
    chk("st_rel_addr", imem_addr,         16'h0004);
    tick();
    chk("st_nxt_inst", INST_IF, 16'hA004);
    chk("st_nxt_npc",  NPC_IF,  16'h0005);

    // 3-cycle memory, redirect during second wait cycle
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("d_req",   {15'd0, imem_req}, 16'h0001);
    chk("d_addr",  imem_addr,         16'h0000);
    chk("d_valid", {15'd0, VALID_IF}, 16'h0000);
    tick();
    chk("d_addr_hold", imem_addr, 16'h0000);
    tick();
    chk("d_new_addr",  imem_addr,         16'h0040);
    chk("d_no_valid",  {15'd0, VALID_IF}, 16'h0000);
    tick(); tick(); tick();
    chk("d_wait_valid", {15'd0, VALID_IF}, 16'h0000);
    tick();
    chk("d_valid1", {15'd0, VALID_IF}, 16'h0001);
    chk("d_npc",    NPC_IF,            16'h0041);
    chk("d_inst",   INST_IF,           16'hA040);

    // redirect coincident with ack and pop
    lat = 0;
    do_reset();
    tick();
    tick();
    chk("c_inst0", INST_IF, 16'hA000);
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("c_valid", {15'd0, VALID_IF}, 16'h0000);
    chk("c_inst",  INST_IF,           16'h0000);
    chk("c_addr",  imem_addr,         16'h0100);
    chk("c_req",   {15'd0, imem_req}, 16'h0001);
    tick();
    chk("c_npc",  NPC_IF,  16'h0101);
    chk("c_inst1", INST_IF, 16'hA100);

    // PC wrap at 16'hFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    chk("w_valid", {15'd0, VALID_IF}, 16'h0000);
    chk("w_addr",  imem_addr,         16'hFFFF);
    tick();
    chk("w_npc",   NPC_IF,    16'h0000);
    chk("w_inst",  INST_IF,   16'h9FFF);
    chk("w_addr2", imem_addr, 16'h0000);

    // reset while draining a cancelled request, then a stray ack
    lat = 3;
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("r_drop_req",  {15'd0, imem_req}, 16'h0001);
    chk("r_drop_addr", imem_addr,         16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_ack = 1'b1;
    chk("r_req",   {15'd0, imem_req}, 16'h0000);
    chk("r_valid", {15'd0, VALID_IF}, 16'h0000);
    chk("r_addr",  imem_addr,         16'h0000);
    tick();
    force_ack = 1'b0;
    chk("r_stale_valid", {15'd0, VALID_IF}, 16'h0000);
    chk("r_req1",        {15'd0, imem_req}, 16'h0001);
    chk("r_addr1",       imem_addr,         16'h0000);
    tick(); tick(); tick();
    chk("r_wait_valid", {15'd0, VALID_IF}, 16'h0000);
    tick();
    chk("r_valid1", {15'd0, VALID_IF}, 16'h0001);
    chk("r_npc",    NPC_IF,            16'h0001);
    chk("r_inst",   INST_IF,           16'hA000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
